// File: rtl/fetch_pc_predictor.sv
// Fetch PC register with next-PC selection and a direct-mapped BTB (2-bit counters).
// Prediction is built only when FETCH_PRED_EN is defined; otherwise fetch falls through to PC+4.
module fetch_pc_predictor #(
    parameter int          ENTRIES  = 16,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStallF,
    input  logic        iMispredictE,
    input  logic [31:0] iRedirectPCE,
    input  logic        iUpdateE,
    input  logic [31:0] iUpdatePCE,
    input  logic [31:0] iUpdateTargetE,
    input  logic        iUpdateTakenE,
    output logic [31:0] oPCF,
    output logic [31:0] oPCPlus4F,
    output logic        oTakeJBF
);

    logic [31:0] pred_next;
    logic [31:0] pc_next;

    assign oPCPlus4F = oPCF + 32'd4;

`ifdef FETCH_PRED_EN
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TW-1:0]      tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [IW-1:0] rd_idx, wr_idx;
    logic [TW-1:0] rd_tag, wr_tag;
    logic          rd_hit, wr_hit;
    logic          unused_bits;

    assign rd_idx = oPCF[IW+1:2];
    assign rd_tag = oPCF[31:IW+2];
    assign wr_idx = iUpdatePCE[IW+1:2];
    assign wr_tag = iUpdatePCE[31:IW+2];

    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign oTakeJBF  = rd_hit && ctr_q[rd_idx][1];
    assign pred_next = oTakeJBF ? target_q[rd_idx] : oPCPlus4F;

    assign unused_bits = ^{iUpdatePCE[1:0], oPCF[1:0]};

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else if (iUpdateE) begin
            if (wr_hit) begin
                if (iUpdateTakenE) begin
                    if (ctr_q[wr_idx] != 2'b11) ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'd1;
                end else begin
                    if (ctr_q[wr_idx] != 2'b00) ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'd1;
                end
            end else if (iUpdateTakenE) begin
                valid_q[wr_idx] <= 1'b1;
                ctr_q[wr_idx]   <= 2'b10;
            end
        end
    end

    // Any taken update either refreshes a hit (tag unchanged) or allocates, so tag
    // and target can be written unconditionally on taken.
    always_ff @(posedge iClk) begin
        if (iUpdateE && iUpdateTakenE) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= iUpdateTargetE;
        end
    end
`else
    logic unused_bits;

    assign oTakeJBF    = 1'b0;
    assign pred_next   = oPCPlus4F;
    assign unused_bits = ^{iUpdateE, iUpdatePCE, iUpdateTargetE, iUpdateTakenE};
`endif

    // Redirect beats stall: a mispredict must land even while fetch is held.
    always_comb begin
        pc_next = pred_next;
        if (iMispredictE)  pc_next = iRedirectPCE;
        else if (iStallF)  pc_next = oPCF;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) oPCF <= RESET_PC;
        else      oPCF <= pc_next;
    end

endmodule

// File: doc/fetch_pc_predictor.md
# fetch_pc_predictor

Fetch-stage program counter unit for the pipelined RV32I core. It holds the fetch PC and chooses the next PC from four sources: a redirect from execute, a stall hold, a predicted-taken branch/jump target, or PC+4. A direct-mapped branch target buffer with 2-bit saturating counters supplies the prediction. The block drives the instruction-memory address and the fetch-side PC and predicted-taken flag that the F/D pipeline register latches.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 2..256.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- iClk  in  1  clock; all state changes on its rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iStallF  in  1  hold the fetch PC.
- iMispredictE  in  1  execute detected a wrong next-PC; redirect fetch.
- iRedirectPCE  in  32  correct next PC when iMispredictE is high.
- iUpdateE  in  1  a branch or jump resolved in execute; train the BTB.
- iUpdatePCE  in  32  PC of the resolved instruction.
- iUpdateTargetE  in  32  resolved target address.
- iUpdateTakenE  in  1  resolved direction (1 = taken).
- oPCF  out  32  current fetch PC (registered).
- oPCPlus4F  out  32  oPCF + 4, modulo 2^32.
- oTakeJBF  out  1  prediction for oPCF: taken.

## Operation
BTB entry fields:
- valid, tag = PC[31:IW+2], target[31:0], ctr[1:0], where IW = log2(ENTRIES).
- Index = PC[IW+1:2]. PC[1:0] are ignored.

Lookup (combinational on oPCF):
- hit = valid & tag match.
- oTakeJBF = hit & ctr[1].
- Predicted next = entry target when oTakeJBF is 1; otherwise oPCPlus4F.

Next-PC priority, highest first:
- iRst: PC = RESET_PC.
- iMispredictE: PC = iRedirectPCE. Applies even when iStallF is high.
- iStallF: hold the current PC.
- Otherwise: the predicted next PC.

Update (on iUpdateE, independent of iStallF and iMispredictE), at index from iUpdatePCE:
- Hit, taken: ctr increments, saturating at 11; target becomes iUpdateTargetE.
- Hit, not taken: ctr decrements, saturating at 00; target is unchanged.
- Miss, taken: allocate (replacing any aliased entry). Set valid = 1, tag and target from the update, ctr = 10.
- Miss, not taken: no change.

Reset (asynchronous):
- PC = RESET_PC.
- All valid bits = 0 and all ctr = 01. Targets and tags are don't-care.
- Outputs during reset: oPCF = RESET_PC, oPCPlus4F = RESET_PC + 4, oTakeJBF = 0.

## Timing
- oPCF changes only on a rising edge or on reset assertion.
- oTakeJBF and oPCPlus4F are combinational from oPCF and BTB state, valid in the same cycle as oPCF.
- Redirect latency is one cycle: iMispredictE high in cycle n gives oPCF = iRedirectPCE in cycle n+1.
- A BTB write in cycle n is visible to lookups from cycle n+1. A lookup at the same index in cycle n sees the old contents.
- PC wraps: 32'hFFFF_FFFC + 4 = 0.
- Reset asserted mid-operation takes effect immediately. The first fetch after release is RESET_PC, with all entries invalid.

## Configuration
- FETCH_PRED_EN defined: BTB and counters are present as described.
- FETCH_PRED_EN undefined:
  - No BTB storage.
  - oTakeJBF is tied to 0.
  - Next PC is iRst, then iMispredictE, then iStallF, then PC+4.
  - iUpdate* inputs are ignored.

## Test plan
All scenarios use ENTRIES=16, RESET_PC=0, FETCH_PRED_EN defined unless noted.
- Reset, then run: iRst held 2 cycles, then released -> oPCF = 0, 4, 8, C on successive cycles; oTakeJBF = 0 throughout.
- Stall: iStallF high 3 cycles at oPCF = 8 -> oPCF stays 8; after release -> C. Same run with iMispredictE=1, iRedirectPCE=0x100, iStallF=1 -> next oPCF = 0x100.
- Allocation: update PC=0x10, taken, target 0x40 -> on the next visit to 0x10, oTakeJBF = 1 and the following oPCF = 0x40; oPCPlus4F = 0x14 while at 0x10.
- Hysteresis at PC 0x10: after allocation (ctr 10), one not-taken update -> ctr 01, oTakeJBF = 0 at 0x10. Two taken updates -> ctr 11. One not-taken update -> ctr 10, still predicts taken.
- Aliasing at PC 0x50 (same index 4 as 0x10, different tag):
  - With 0x10 allocated, 0x50 misses -> oTakeJBF = 0.
  - Taken update at 0x50 with target 0x80 -> 0x50 predicts 0x80; 0x10 now misses.
  - Update and lookup at the same index in one cycle -> the lookup sees the old entry.
- FETCH_PRED_EN undefined: same stimulus as the allocation scenario -> oTakeJBF = 0 and oPCF = 0x14 after 0x10; redirect to 0x200 still lands in one cycle.
